audio_deser: RTL

- Parametrised stereo serial-to-parallel receiver for the codec ADC data line (WM8731-class bit clock plus LR clock).
- Captures both channels MSB-first and publishes an aligned left/right word pair once per frame, with a one-cycle valid strobe and a short-word error flag.
- Supports I2S (one-bit delay) and left-justified framing.
- Sits between the codec pins and the sample-processing datapath.
- Optionally generates the frame-rate square-wave monitor tone.

---
 rtl/audio_deser.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/audio_deser.sv
// Stereo serial-to-parallel receiver for a codec ADC line (bit clock + LR clock), I2S or left-justified.
// Latency: the left/right pair is presented 1 clk after the LRC rise that closes the right half-frame.
// Backpressure: none; the codec free-runs, so each pair is a one-cycle strobe and must be taken when offered.
//
// Ports:
//   clk          codec bit clock, all logic on posedge
//   rst          synchronous active-high reset
//   reclrc       LR clock (1 = left half-frame, 0 = right half-frame)
//   sin          serial ADC data, MSB first
//   left_out     last complete left word (DATA_W bits, left-aligned)
//   right_out    last complete right word (DATA_W bits, left-aligned)
//   sample_valid one-cycle pulse when left_out/right_out update
//   frame_err    set with sample_valid when either word of the pair was short
//   tone_out     frame-rate monitor tone
//
// Optional feature: define AUDIO_DESER_TONE_EN to build the 10-bit frame counter
// and the monitor tone; otherwise tone_out is tied to 0.
module audio_deser #(
  parameter int DATA_W   = 16,
  parameter int I2S_MODE = 1,
  parameter int TONE_BIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reclrc,
  input  logic              sin,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              tone_out
);

  localparam int POS_W  = $clog2(DATA_W + 2);
  localparam int FILL_W = $clog2(DATA_W + 1);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(DATA_W + 1);
  localparam logic [POS_W-1:0]  CAP_OFS  = POS_W'(I2S_MODE);
  localparam logic [POS_W-1:0]  CAP_LEN  = POS_W'(DATA_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DATA_W);
  localparam logic [DATA_W-1:0] MSB_ONE  = DATA_W'(1) << (DATA_W - 1);

  if (DATA_W < 1 || DATA_W > 32 || TONE_BIT < 0 || TONE_BIT > 9) begin : g_param_chk
    $error("audio_deser: DATA_W must be 1..32 and TONE_BIT 0..9");
  end

  logic              lrc_d;
  logic              lrc_ok;     // lrc_d holds a real sample (not the reset value)
  logic              rise, fall, lrc_edge;
  logic [POS_W-1:0]  pos_cnt, pos, rel_pos;
  logic              cap;
  logic [DATA_W-1:0] sreg_l, sreg_r, sl_base, sr_base, sl_next, sr_next;
  logic [FILL_W-1:0] fill_l, fill_r, fl_base, fr_base, fl_next, fr_next;
  logic [DATA_W-1:0] left_hold;
  logic              hold_short;
  logic              seen_rise;
  logic              armed;

  always_comb begin
    // The first cycle out of reset compares reclrc against the reset value of
    // lrc_d; that is not a real LRC transition, so it must not start a frame
    // (otherwise a partial left half-frame could be published after reset).
    rise     = lrc_ok & reclrc & ~lrc_d;
    fall     = lrc_ok & ~reclrc & lrc_d;
    lrc_edge = rise | fall;
    pos      = lrc_edge ? '0 : pos_cnt;
    // pos below the offset wraps to a large value, so one unsigned compare
    // covers the whole [0, DATA_W-1] capture window.
    rel_pos  = pos - CAP_OFS;
    cap      = (rel_pos < CAP_LEN);

    // Both channels restart at the rise that opens a new frame.
    sl_base  = rise ? '0 : sreg_l;
    fl_base  = rise ? '0 : fill_l;
    sr_base  = rise ? '0 : sreg_r;
    fr_base  = rise ? '0 : fill_r;
    sl_next  = sl_base;
    fl_next  = fl_base;
    sr_next  = sr_base;
    fr_next  = fr_base;

    // Bits land at their final left-aligned position, so a short word is
    // already MSB-aligned with zero LSBs when the half-frame ends.
    if (cap && reclrc && (fl_base != FILL_MAX)) begin
      if (sin) sl_next = sl_base | (MSB_ONE >> fl_base);
      fl_next = fl_base + FILL_W'(1);
    end
    if (cap && !reclrc && (fr_base != FILL_MAX)) begin
      if (sin) sr_next = sr_base | (MSB_ONE >> fr_base);
      fr_next = fr_base + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lrc_d        <= 1'b0;
      lrc_ok       <= 1'b0;
      pos_cnt      <= '0;
      sreg_l       <= '0;
      sreg_r       <= '0;
      fill_l       <= '0;
      fill_r       <= '0;
      left_hold    <= '0;
      hold_short   <= 1'b0;
      seen_rise    <= 1'b0;
      armed        <= 1'b0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      lrc_d        <= reclrc;
      lrc_ok       <= 1'b1;
      pos_cnt      <= (pos == POS_MAX) ? pos : pos + POS_W'(1);
      sreg_l       <= sl_next;
      sreg_r       <= sr_next;
      fill_l       <= fl_next;
      fill_r       <= fr_next;
      sample_valid <= 1'b0;
      if (fall) begin
        left_hold  <= sreg_l;
        hold_short <= (fill_l != FILL_MAX);
        // Arm only once a whole left half-frame (rise..fall) has been seen,
        // so the first pair after reset is never published.
        if (seen_rise) armed <= 1'b1;
      end
      if (rise) begin
        seen_rise <= 1'b1;
        if (armed) begin
          left_out     <= left_hold;
          right_out    <= sreg_r;
          sample_valid <= 1'b1;
          frame_err    <= hold_short | (fill_r != FILL_MAX);
        end
      end
    end
  end

`ifdef AUDIO_DESER_TONE_EN
  logic [9:0] frame_cnt;
  logic       tone_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      tone_q    <= 1'b0;
    end else begin
      if (rise) frame_cnt <= frame_cnt + 10'd1;
      tone_q <= reclrc ? frame_cnt[TONE_BIT] : ~frame_cnt[TONE_BIT];
    end
  end

  assign tone_out = tone_q;
`else
  assign tone_out = 1'b0;
`endif

endmodule
